// File: rtl/dmem_bus_pkg.sv
// Shared types for the data-memory bus bridge.
// FSM states, request/response bundles, timeout default.
package dmem_bus_pkg;

  localparam int DMEM_DW = 32;
  localparam int DMEM_MW = DMEM_DW / 8;
  localparam int DMEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  typedef struct packed {
    logic               we;
    logic [DMEM_DW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic [DMEM_MW-1:0] mask;
  } dmem_bus_req_t;

  typedef struct packed {
    logic [DMEM_DW-1:0] rdata;
    logic               err;
  } dmem_bus_rsp_t;

  function automatic logic [DMEM_DW-1:0] word_addr(
    input logic [DMEM_DW-1:0] a
  );
    return {a[DMEM_DW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Access watchdog for the dmem bus bridge.
// Saturates at TIMEOUT_CYCLES so expiry stays asserted.
module bus_timeout_counter
  import dmem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic arst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_EXP =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Clear wins; otherwise count busy cycles up to the cap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= CNT_EXP);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Memory-stage to data-memory bus bridge.
// One access in flight; stalls the core until done.
module dmem_bus_bridge
  import dmem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DW,
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  localparam int MASK_SIZE = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [MASK_SIZE-1:0]  cpu_mask,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [MASK_SIZE-1:0]  bus_mask,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rsp_err
);

  state_t        state_q;
  state_t        state_d;
  dmem_bus_req_t req_q;
  dmem_bus_req_t req_d;
  dmem_bus_rsp_t rsp_q;
  dmem_bus_rsp_t rsp_d;

  logic cnt_clr;
  logic cnt_en;
  logic expired;

  assign cnt_clr = (state_q == IDLE);
  assign cnt_en  = (state_q == REQ) ||
                   (state_q == RESP);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .arst     (arst),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .expired_o(expired)
  );

  // Next state, request capture and response capture.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          state_d     = REQ;
          req_d.we    = cpu_req_we;
          req_d.addr  = cpu_addr;
          req_d.wdata = cpu_wdata;
          req_d.mask  = cpu_mask;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = RESP;
        end else if (expired) begin
          state_d     = DONE;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
        end
      end
      RESP: begin
        if (bus_rsp_valid) begin
          state_d     = DONE;
          rsp_d.rdata = req_q.we ? '0 : bus_rdata;
          rsp_d.err   = bus_rsp_err;
        end else if (expired) begin
          state_d     = DONE;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cpu_stall = !arst && (
    ((state_q == IDLE) && cpu_req_valid) ||
    (state_q == REQ) ||
    (state_q == RESP));

  assign cpu_done  = (state_q == DONE);
  assign cpu_err   = (state_q == DONE) && rsp_q.err;
  assign cpu_rdata = rsp_q.rdata;

  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = req_q.we;
  assign bus_addr      = word_addr(req_q.addr);
  assign bus_wdata     = req_q.wdata;
  assign bus_mask      = req_q.we ? req_q.mask : '1;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge.
// Slave timing is chosen up front; a model predicts outcome.
module tb_dmem_bus_bridge;

  localparam int T = 8;

  logic        clk;
  logic        arst;
  logic        cpu_req_valid;
  logic        cpu_req_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_rsp_err;

  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int exp_hs = 0;
  logic [31:0] hold_rd = '0;

  dmem_bus_bridge #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_we   (cpu_req_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_mask     (cpu_mask),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_mask     (bus_mask),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata    (bus_rdata),
    .bus_rsp_err  (bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!arst && bus_req_valid && bus_req_ready)
      hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic gap(input bit noise);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_addr      = $urandom;
    bus_req_ready = 1'($urandom);
    bus_rsp_valid = noise ? 1'b1 : 1'($urandom);
    bus_rsp_err   = 1'($urandom);
    bus_rdata     = $urandom;
    #1;
    chk("gap_stall", cpu_stall, 0);
    chk("gap_bvalid", bus_req_valid, 0);
    chk("gap_done", cpu_done, 0);
    chk("gap_err", cpu_err, 0);
    chk("gap_rdata", cpu_rdata, hold_rd);
  endtask

  // dr: REQ cycles with ready low before the handshake.
  // drsp: RESP cycles before rsp_valid.
  task automatic access(
    input bit          we,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [3:0]  m,
    input int          dr,
    input int          drsp,
    input bit          rerr,
    input logic [31:0] rd
  );
    int rsp_k;
    int last_k;
    int done_k;
    bit tmo;
    bit e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_m;
    e_m   = we ? m : 4'hF;
    rsp_k = 1 << 20;
    if (dr > T - 1) begin
      tmo    = 1'b1;
      done_k = T;
    end else begin
      rsp_k  = dr + 1 + drsp;
      last_k = (dr + 1 > T - 1) ? dr + 1 : T - 1;
      if (rsp_k <= last_k) begin
        tmo    = 1'b0;
        done_k = rsp_k + 1;
      end else begin
        tmo    = 1'b1;
        done_k = last_k + 1;
      end
      exp_hs++;
    end
    e_err = tmo ? 1'b1 : rerr;
    e_rd  = (tmo || we) ? 32'h0 : rd;

    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_addr      = a;
    cpu_wdata     = wd;
    cpu_mask      = m;
    bus_req_ready = 1'($urandom);
    bus_rsp_valid = 1'($urandom);
    bus_rsp_err   = 1'($urandom);
    bus_rdata     = $urandom;
    #1;
    chk("idle_stall", cpu_stall, 1);
    chk("idle_bvalid", bus_req_valid, 0);
    chk("idle_done", cpu_done, 0);
    chk("idle_rdata", cpu_rdata, hold_rd);

    for (int k = 0; k <= done_k; k++) begin
      if (k > 0) @(negedge clk);
      if (k > 0) begin
        if (k <= dr && k < done_k)
          bus_req_ready = (k == dr);
        else
          bus_req_ready = 1'($urandom);
        if (k > dr && k < done_k) begin
          bus_rsp_valid = (k == rsp_k);
          bus_rsp_err   = rerr;
          bus_rdata     = (k == rsp_k) ? rd : $urandom;
        end else begin
          bus_rsp_valid = 1'($urandom);
          bus_rsp_err   = 1'($urandom);
          bus_rdata     = $urandom;
        end
        #1;
      end else begin
        @(negedge clk);
        bus_req_ready = (dr == 0);
        bus_rsp_valid = 1'($urandom);
        bus_rsp_err   = 1'($urandom);
        bus_rdata     = $urandom;
        #1;
      end
      if (k < done_k) begin
        chk("busy_stall", cpu_stall, 1);
        chk("busy_done", cpu_done, 0);
        chk("busy_err", cpu_err, 0);
        chk("busy_rdata", cpu_rdata, hold_rd);
        chk("busy_bvalid", bus_req_valid, (k <= dr));
        if (k <= dr) begin
          chk("bus_addr", bus_addr, a & ~32'h3);
          chk("bus_we", bus_we, we);
          chk("bus_wdata", bus_wdata, wd);
          chk("bus_mask", bus_mask, e_m);
        end
      end else begin
        chk("done_pulse", cpu_done, 1);
        chk("done_stall", cpu_stall, 0);
        chk("done_err", cpu_err, e_err);
        chk("done_rdata", cpu_rdata, e_rd);
        chk("done_bvalid", bus_req_valid, 0);
      end
    end
    hold_rd = e_rd;
  endtask

  task automatic reset_mid_resp();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_addr      = 32'h0000_0510;
    cpu_wdata     = $urandom;
    cpu_mask      = 4'hF;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    chk("rst_pre_stall", cpu_stall, 1);
    chk("rst_pre_bvalid", bus_req_valid, 0);
    exp_hs++;
    #2;
    arst = 1'b1;
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_bvalid", bus_req_valid, 0);
    chk("rst_baddr", bus_addr, 0);
    chk("rst_bwdata", bus_wdata, 0);
    hold_rd = '0;
    @(negedge clk);
    arst          = 1'b0;
    cpu_req_valid = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_err   = 1'b1;
    bus_rdata     = 32'hCAFE_F00D;
    gap(1'b0);
    gap(1'b0);
  endtask

  initial begin
    arst          = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    cpu_mask      = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rdata     = 32'h5555_AAAA;
    bus_rsp_err   = 1'b1;
    #12;
    chk("por_stall", cpu_stall, 0);
    chk("por_done", cpu_done, 0);
    chk("por_err", cpu_err, 0);
    chk("por_rdata", cpu_rdata, 0);
    chk("por_bvalid", bus_req_valid, 0);
    @(negedge clk);
    arst = 1'b0;
    gap(1'b0);

    access(0, 32'h0000_0106, $urandom, 4'h3,
           0, 0, 0, 32'hDEAD_BEEF);
    gap(0);
    access(1, 32'h0000_0200, 32'h0000_AB00,
           4'b0010, 5, 1, 0, $urandom);
    gap(0);
    access(0, 32'h0000_0300, $urandom, 4'hF,
           20, 0, 0, $urandom);
    gap(1);
    gap(1);
    access(0, 32'h0000_0044, $urandom, 4'hF,
           1, 2, 1, 32'h0000_1234);
    access(0, 32'h0000_0800, $urandom, 4'hF,
           0, 0, 0, 32'h1111_2222);
    access(1, 32'h0000_0804, 32'h3333_4444,
           4'hC, 0, 0, 0, $urandom);
    gap(0);
    access(0, 32'h0000_0900, $urandom, 4'hF,
           T - 1, 0, 0, 32'h7777_0001);
    gap(0);
    access(0, 32'h0000_0904, $urandom, 4'hF,
           T - 1, 1, 0, 32'h7777_0002);
    gap(0);
    reset_mid_resp();
    access(0, 32'h0000_0514, $urandom, 4'hF,
           0, 0, 0, 32'h0BAD_CAFE);

    for (int i = 0; i < 150; i++) begin
      int dr;
      int drsp;
      dr = ($urandom_range(0, 9) < 8) ?
           int'($urandom_range(0, 3)) :
           int'($urandom_range(5, 12));
      drsp = ($urandom_range(0, 9) < 8) ?
             int'($urandom_range(0, 3)) :
             int'($urandom_range(4, 10));
      access(1'($urandom), $urandom, $urandom,
             4'($urandom), dr, drsp,
             ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 2) == 0)
        gap(1'($urandom));
    end

    gap(0);
    chk("handshakes", hs_cnt, exp_hs);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
